uart_parity_tx: RTL and testbench

UART transmit serializer with even-parity generation; the transmit-side counterpart of the receiver's 9-bit parity check, where the checker expects bit 8 equal to the XOR of bits 7:0. It accepts a byte over a valid/ready handshake, computes the parity bit and shifts out the frame LSB first. The frame is start(0), D0..D7, P, then STOP_BITS stop bits (1). It sits between the host/user logic and the serial tx pin.

---
 rtl/uart_parity_tx.sv | 144 ++++++++++++++
 tb/tb_uart_parity_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity bit, then
// STOP_BITS stop bits. Accepts one byte per frame over a valid/ready handshake.
module uart_parity_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              baud_last, baud_pre_last, stop_last, accept;

   // Ready depends only on state and reset, never on data_valid.
   assign data_ready = (state_q == S_IDLE) && rst_n;
   assign accept     = data_valid && data_ready;

   assign baud_last     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign baud_pre_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 2));
   assign stop_last     = (bit_idx_q == 3'(STOP_BITS - 1));

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_d        = par_q;
      frame_done_d = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_START;
               baud_d    = '0;
               bit_idx_d = '0;
               shift_d   = data_in;
               par_d     = ^data_in;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  state_d   = S_PARITY;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               state_d   = S_STOP;
               bit_idx_d = '0;
            end
         end
         S_STOP: begin
            // Registered pulse: raise it one cycle early so it lands on the last stop cycle.
            if (baud_pre_last && stop_last) begin
               frame_done_d = 1'b1;
            end
            if (baud_last) begin
               if (stop_last) begin
                  state_d = S_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Line level follows the state being entered so tx is a clean flop output.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_parity_tx.sv
// Self-checking bench for uart_parity_tx: one instance with a single stop bit,
// one with two, compared cycle by cycle against a bit-list frame model.
module tb_uart_parity_tx;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       sel2 = 1'b0;

   logic dv1, dv2;
   logic rdy1, tx1, busy1, fd1;
   logic rdy2, tx2, busy2, fd2;
   logic rdy_m, tx_m, busy_m, fd_m;

   int checks = 0;
   int errors = 0;
   int last_waited = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   assign dv1    = data_valid & ~sel2;
   assign dv2    = data_valid & sel2;
   assign rdy_m  = sel2 ? rdy2  : rdy1;
   assign tx_m   = sel2 ? tx2   : tx1;
   assign busy_m = sel2 ? busy2 : busy1;
   assign fd_m   = sel2 ? fd2   : fd1;

   uart_parity_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(dv1),
      .data_ready(rdy1), .tx(tx1), .busy(busy1), .frame_done(fd1)
   );

   uart_parity_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(dv2),
      .data_ready(rdy2), .tx(tx2), .busy(busy2), .frame_done(fd2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected line level for every clock of a frame, built from the bit list.
   function automatic void build(input logic [7:0] d, input int sb);
      bit lv[$];
      exp_q.delete();
      lv.push_back(1'b0);
      for (int k = 0; k < 8; k++) lv.push_back(d[k]);
      lv.push_back(^d);
      for (int k = 0; k < sb; k++) lv.push_back(1'b1);
      foreach (lv[k]) for (int r = 0; r < C; r++) exp_q.push_back(lv[k]);
   endfunction

   // Receiver-side check: returns {parity_error, data}.
   function automatic logic [8:0] rx_check(input logic [8:0] w);
      return {^w, w[7:0]};
   endfunction

   // Entered and left at a negedge with the selected DUT idle.
   task automatic do_frame(input logic [7:0] d, input bit chain, input logic [7:0] nxt,
                           input int inject_at, input int rst_at,
                           output logic [8:0] word9, output int busy_cnt, output int fd_cnt);
      int n;
      int k;
      build(d, sel2 ? 2 : 1);
      n = exp_q.size();
      word9 = '0;
      busy_cnt = 0;
      fd_cnt = 0;
      data_in = d;
      data_valid = 1'b1;
      last_waited = 0;
      while (!rdy_m && last_waited < 200) begin
         @(negedge clk);
         last_waited++;
      end
      if (!rdy_m) begin
         chk("accept_timeout", 32'(rdy_m), 32'd1);
         data_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (chain) data_in = nxt;
      else data_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == inject_at) begin
            data_in = 8'h3C;
            data_valid = 1'b1;
         end else if (i == inject_at + 1) begin
            data_valid = 1'b0;
         end
         chk("tx_wave", 32'(tx_m), 32'(exp_q[i]));
         chk("frame_done_wave", 32'(fd_m), 32'(i == n - 1));
         busy_cnt += int'(busy_m);
         fd_cnt += int'(fd_m);
         k = i / C;
         if ((i % C) == C / 2 && k >= 1 && k <= 9) word9[k-1] = tx_m;
         if (i == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("rst_abort_tx", 32'(tx_m), 32'd1);
            chk("rst_abort_busy", 32'(busy_m), 32'd0);
            for (int j = 0; j < n; j++) begin
               chk("rst_no_frame_done", 32'(fd_m), 32'd0);
               chk("rst_idle_tx", 32'(tx_m), 32'd1);
               @(negedge clk);
            end
            return;
         end
         @(negedge clk);
      end
      chk("gap_tx", 32'(tx_m), 32'd1);
      chk("gap_busy", 32'(busy_m), 32'd0);
      chk("gap_ready", 32'(rdy_m), 32'd1);
      chk("gap_frame_done", 32'(fd_m), 32'd0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       exp_par;
   } vec_t;

   initial begin
      vec_t       vecs[8];
      logic [8:0] w;
      logic [8:0] rx;
      int         bc, fc, inj;
      logic [7:0] rb;

      vecs[0] = '{8'hA5, 1'b0};
      vecs[1] = '{8'h07, 1'b1};
      vecs[2] = '{8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b0};
      vecs[4] = '{8'h01, 1'b1};
      vecs[5] = '{8'h80, 1'b1};
      vecs[6] = '{8'h5A, 1'b0};
      vecs[7] = '{8'h7F, 1'b1};

      // Reset held for 3 clocks.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx1", 32'(tx1), 32'd1);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_fd1", 32'(fd1), 32'd0);
      chk("rst_ready_low", 32'(rdy1), 32'd0);
      chk("rst_tx2", 32'(tx2), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready1", 32'(rdy1), 32'd1);
      chk("rel_ready2", 32'(rdy2), 32'd1);
      chk("rel_tx1", 32'(tx1), 32'd1);

      foreach (vecs[v]) begin
         repeat (2) @(negedge clk);
         do_frame(vecs[v].data, 1'b0, 8'h00, -1, -1, w, bc, fc);
         rx = rx_check(w);
         chk("vec_parity", 32'(w[8]), 32'(vecs[v].exp_par));
         chk("vec_rx_data", 32'(rx[7:0]), 32'(vecs[v].data));
         chk("vec_rx_perr", 32'(rx[8]), 32'd0);
         chk("vec_busy_len", 32'(bc), 32'd44);
         chk("vec_fd_count", 32'(fc), 32'd1);
      end

      // Back-to-back with data_valid held high.
      @(negedge clk);
      do_frame(8'h00, 1'b1, 8'hFF, -1, -1, w, bc, fc);
      chk("b2b_par0", 32'(w[8]), 32'd0);
      do_frame(8'hFF, 1'b0, 8'h00, -1, -1, w, bc, fc);
      chk("b2b_no_wait", 32'(last_waited), 32'd0);
      chk("b2b_par1", 32'(w[8]), 32'd0);
      chk("b2b_data1", 32'(w[7:0]), 32'hFF);

      // Byte offered while busy is dropped.
      do_frame(8'hA5, 1'b0, 8'h00, 15, -1, w, bc, fc);
      chk("busy_ignore_data", 32'(w[7:0]), 32'hA5);
      chk("busy_ignore_fd", 32'(fc), 32'd1);
      repeat (3) @(negedge clk);
      chk("busy_ignore_idle", 32'(busy1), 32'd0);

      // Reset during data bit 3, then a clean frame.
      do_frame(8'hA5, 1'b0, 8'h00, -1, 17, w, bc, fc);
      do_frame(8'h5A, 1'b0, 8'h00, -1, -1, w, bc, fc);
      chk("post_rst_data", 32'(w[7:0]), 32'h5A);
      chk("post_rst_fd", 32'(fc), 32'd1);

      // Random bytes, gaps and occasional mid-frame offers.
      for (int r = 0; r < 16; r++) begin
         rb = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : -1;
         do_frame(rb, 1'b0, 8'h00, inj, -1, w, bc, fc);
         rx = rx_check(w);
         chk("rand_rx_data", 32'(rx[7:0]), 32'(rb));
         chk("rand_rx_perr", 32'(rx[8]), 32'd0);
         chk("rand_fd_count", 32'(fc), 32'd1);
      end

      // Two stop bits.
      sel2 = 1'b1;
      @(negedge clk);
      do_frame(8'hA5, 1'b0, 8'h00, -1, -1, w, bc, fc);
      chk("stop2_busy_len", 32'(bc), 32'd48);
      chk("stop2_fd_count", 32'(fc), 32'd1);
      do_frame(8'h07, 1'b0, 8'h00, -1, -1, w, bc, fc);
      chk("stop2_par", 32'(w[8]), 32'd1);
      chk("stop2_data", 32'(w[7:0]), 32'h07);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
